// File: rtl/ram_stream_pkg.sv
// Shared constants and types for the RAM stream reader slice.
//   DEPTH  - number of memory words
//   WIDTH  - bits per memory word
//   ADDR_W - word address width
//   LEN_W  - burst length field width (holds 0..31, legal bursts are 1..DEPTH)
//   state_t - burst FSM state
package ram_stream_pkg;

  localparam int DEPTH  = 16;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 4;
  localparam int LEN_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for a valid start
    READ  = 2'd1,  // still issuing memory reads
    DRAIN = 2'd2   // all reads issued, buffered words still pending
  } state_t;

  // Legal burst lengths are 1..depth; anything else rejects the request.
  function automatic logic len_ok(input logic [LEN_W-1:0] len, input int depth);
    return (len != '0) && (int'(len) <= depth);
  endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// Output word stream of the RAM stream reader (valid/ready handshake).
//   out_valid - out_data/out_addr hold a valid word
//   out_ready - sink accepts the word when out_valid && out_ready
//   out_data  - word read from memory
//   out_addr  - address the word was read from
// master: the reader (drives the word); slave: the downstream sink.
interface ram_stream_reader_if;
  import ram_stream_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [ADDR_W-1:0] out_addr;

  modport master (output out_valid, out_data, out_addr, input out_ready);
  modport slave  (input out_valid, out_data, out_addr, output out_ready);

endinterface

// File: rtl/ram16x32.sv
// Single-port synchronous RAM, 16 words x 32 bits.
//   clk     - clock
//   we      - write strobe, writes din to mem[address] at the rising edge
//   address - shared read/write address
//   din     - write data
//   dout    - registered read data, mem[address] one cycle after presentation
// Reads are read-first: a write cycle returns the old contents on dout.
module ram16x32
  import ram_stream_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array and its read register carry no reset; a reset
  // must leave memory contents intact, and a resettable array would not map
  // onto block RAM anyway.
  always_ff @(posedge clk) begin
    if (we) mem[address] <= din;
    dout <= mem[address];
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader streaming consecutive words of a 16x32 RAM to a valid/ready sink.
//   clk        - sole clock, rising edge
//   rst        - synchronous active-high reset
//   we         - host write strobe (priority over streamer reads)
//   address    - host write address
//   din        - host write data
//   start      - one-cycle burst request
//   start_addr - first address of the burst
//   length     - burst word count, 1..DEPTH, otherwise the request is ignored
//   busy       - high from the cycle after an accepted start until done
//   done       - one-cycle pulse when the burst has fully drained
//   out_if     - output word stream (master side)
// Reads go through a 1-cycle-latency RAM into a 2-entry output FIFO. A read is
// only issued when the FIFO is guaranteed to have room for the returning word.
module ram_stream_reader
  import ram_stream_pkg::ADDR_W, ram_stream_pkg::LEN_W;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    address,
  input  logic [WIDTH-1:0]     din,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_addr,
  input  logic [LEN_W-1:0]     length,
  output logic                 busy,
  output logic                 done,
  ram_stream_reader_if.master  out_if
);

  import ram_stream_pkg::state_t;
  import ram_stream_pkg::IDLE;
  import ram_stream_pkg::READ;
  import ram_stream_pkg::DRAIN;
  import ram_stream_pkg::len_ok;

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;      // next address to read
  logic [LEN_W-1:0]  issue_left;   // reads still to issue in this burst
  logic              in_flight;    // a read was issued at the last edge
  logic [ADDR_W-1:0] flight_addr;  // address of the in-flight read

  // Output FIFO held as head/tail registers so the head drives the port directly.
  logic [1:0]        fifo_count;
  logic [WIDTH-1:0]  head_data, tail_data;
  logic [ADDR_W-1:0] head_addr, tail_addr;

  logic [WIDTH-1:0]  ram_dout;
  logic [ADDR_W-1:0] ram_addr;
  logic              pop;
  logic              issue;
  logic [2:0]        occupancy;

  assign pop = (fifo_count != 2'd0) && out_if.out_ready;

  // Slots committed after this edge: buffered words plus the word returning
  // now, minus the word leaving now. Counting the pop lets a read issue in the
  // same cycle a slot frees, which is what sustains one word per cycle.
  assign occupancy = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};

  // Host writes own the single RAM port; the streamer retries next cycle.
  assign issue    = (state == READ) && !we && (occupancy < 3'd2);
  assign ram_addr = we ? address : rd_addr;

  ram16x32 u_ram (
    .clk     (clk),
    .we      (we),
    .address (ram_addr),
    .din     (din),
    .dout    (ram_dout)
  );

  assign out_if.out_valid = (fifo_count != 2'd0);
  assign out_if.out_data  = head_data;
  assign out_if.out_addr  = head_addr;

  // Read pipeline and output FIFO. ram_dout is valid exactly one cycle after
  // issue, so in_flight doubles as the FIFO push strobe.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight   <= 1'b0;
      flight_addr <= '0;
      fifo_count  <= 2'd0;
      head_data   <= '0;
      head_addr   <= '0;
      tail_data   <= '0;
      tail_addr   <= '0;
    end else begin
      in_flight <= issue;
      if (issue) flight_addr <= rd_addr;

      case ({in_flight, pop})
        2'b10: begin
          if (fifo_count == 2'd0) begin
            head_data <= ram_dout;
            head_addr <= flight_addr;
          end else begin
            tail_data <= ram_dout;
            tail_addr <= flight_addr;
          end
          fifo_count <= fifo_count + 2'd1;
        end
        2'b01: begin
          head_data  <= tail_data;
          head_addr  <= tail_addr;
          fifo_count <= fifo_count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the incoming word goes behind whatever remains.
          if (fifo_count == 2'd1) begin
            head_data <= ram_dout;
            head_addr <= flight_addr;
          end else begin
            head_data <= tail_data;
            head_addr <= tail_addr;
            tail_data <= ram_dout;
            tail_addr <= flight_addr;
          end
        end
        default: ;
      endcase
    end
  end

  // Burst FSM with registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_addr    <= '0;
      issue_left <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && len_ok(length, DEPTH)) begin
            state      <= READ;
            busy       <= 1'b1;
            rd_addr    <= start_addr;
            issue_left <= length;
          end
        end
        READ: begin
          if (issue) begin
            rd_addr    <= rd_addr + 1'b1;  // wraps 15 -> 0
            issue_left <= issue_left - 1'b1;
            if (issue_left == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((fifo_count == 2'd0) && !in_flight) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: directed bursts plus randomized
// bursts with random back-pressure and host writes, scored against a memory
// image and burst descriptor kept in the bench.
module tb_ram_stream_reader;
  import ram_stream_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic [ADDR_W-1:0] address;
  logic [WIDTH-1:0]  din;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;

  ram_stream_reader_if out_if ();

  ram_stream_reader dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .address    (address),
    .din        (din),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .out_if     (out_if)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [31:0] mem_model [16];
  int          exp_start, exp_len;
  bit          exp_active;
  int          delivered, done_count;
  int          cyc, first_cyc, last_cyc;
  bit          prev_stall;
  logic [31:0] prev_data;
  logic [3:0]  prev_addr;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Sink-side scoreboard, evaluated on the falling edge where inputs are stable.
  task automatic observe();
    int a;
    @(negedge clk);
    if (!rst) begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_if.out_valid), 32'd1);
        check("hold_data", out_if.out_data, prev_data);
        check("hold_addr", 32'(out_if.out_addr), 32'(prev_addr));
      end
      if (out_if.out_valid && out_if.out_ready) begin
        check("in_burst", 32'(exp_active && (delivered < exp_len)), 32'd1);
        a = (exp_start + delivered) % 16;
        check("word_addr", 32'(out_if.out_addr), 32'(a));
        check("word_data", out_if.out_data, mem_model[a]);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        delivered++;
      end
      if (done) begin
        done_count++;
        check("words_per_burst", 32'(delivered), 32'(exp_len));
      end
    end
    prev_stall = !rst && out_if.out_valid && !out_if.out_ready;
    prev_data  = out_if.out_data;
    prev_addr  = out_if.out_addr;
  endtask

  task automatic tick();
    observe();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic logic ready_val(input int mode, input int t);
    case (mode)
      0:       return 1'b1;
      1:       return (t % 4 == 0) || (t % 4 == 3);  // 1,0,0,1
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic host_write(input int a, input logic [31:0] d);
    we = 1'b1; address = 4'(a); din = d;
    mem_model[a] = d;
    tick();
    we = 1'b0;
  endtask

  task automatic begin_burst(input int s, input int len);
    exp_start  = s;
    exp_len    = len;
    exp_active = 1'b1;
    delivered  = 0;
    first_cyc  = -1;
    last_cyc   = -1;
    start      = 1'b1;
    start_addr = 4'(s);
    length     = 5'(len);
  endtask

  task automatic run_burst(input int s, input int len, input int rmode,
                           input int we_off, input int we_n, input int we_a,
                           input logic [31:0] we_d, input bit rand_we,
                           input bit dup_start, output int first_delay, output int span);
    int done0, t, start_cyc, a, j;
    done0 = done_count;
    begin_burst(s, len);
    out_if.out_ready = ready_val(rmode, 0);
    tick();
    start_cyc = cyc;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    t = 0;
    while ((done_count == done0) && (t < 400)) begin
      out_if.out_ready = ready_val(rmode, t + 1);
      we    = 1'b0;
      start = dup_start && (t == 2);
      start_addr = 4'd7;
      length     = 5'd3;
      if ((we_off >= 0) && (t >= we_off) && (t < we_off + we_n)) begin
        we = 1'b1; address = 4'(we_a); din = we_d;
        mem_model[we_a] = we_d;
      end else if (rand_we && ($urandom_range(0, 3) == 0)) begin
        // Only touch words that are outside the issued-but-undelivered window.
        a = $urandom_range(0, 15);
        j = (a - exp_start + 16) % 16;
        if ((j >= exp_len) || (j < delivered) || (j > delivered + 4)) begin
          we = 1'b1; address = 4'(a); din = $urandom;
          mem_model[a] = din;
        end
      end
      tick();
      t++;
    end
    we = 1'b0;
    start = 1'b0;
    out_if.out_ready = 1'b1;
    check("done_seen", 32'(done_count - done0), 32'd1);
    exp_active = 1'b0;
    repeat (3) tick();
    check("done_once", 32'(done_count - done0), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
    first_delay = first_cyc - start_cyc;
    span        = last_cyc - first_cyc + 1;
  endtask

  task automatic invalid_start(input int len);
    int d0;
    d0 = done_count;
    start = 1'b1; start_addr = 4'($urandom_range(0, 15)); length = 5'(len);
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("inv_busy", 32'(busy), 32'd0);
    check("inv_no_done", 32'(done_count - d0), 32'd0);
  endtask

  initial begin
    int fd, sp, d0, t;
    cyc = 0; done_count = 0; delivered = 0; exp_active = 1'b0;
    exp_start = 0; exp_len = 0; first_cyc = -1; last_cyc = -1; prev_stall = 1'b0;
    rst = 1'b1; we = 1'b0; address = '0; din = '0;
    out_if.out_ready = 1'b1;
    // A start during reset must be ignored.
    start = 1'b1; start_addr = 4'd3; length = 5'd4;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(out_if.out_valid), 32'd0);
    check("rst_data", out_if.out_data, 32'd0);
    check("rst_addr", 32'(out_if.out_addr), 32'd0);

    for (int i = 0; i < 16; i++) host_write(i, 32'(8 * i));

    // Full burst at full rate
    run_burst(0, 16, 0, -1, 0, 0, 32'd0, 1'b0, 1'b0, fd, sp);
    check("full_first_delay", 32'(fd), 32'd2);
    check("full_span", 32'(sp), 32'd16);

    // Wrapping burst
    run_burst(14, 4, 0, -1, 0, 0, 32'd0, 1'b0, 1'b0, fd, sp);
    check("wrap_first_delay", 32'(fd), 32'd2);
    check("wrap_span", 32'(sp), 32'd4);

    // Back-pressure 1,0,0,1
    run_burst(0, 16, 1, -1, 0, 0, 32'd0, 1'b0, 1'b0, fd, sp);

    // Host write of word 5 for three cycles ahead of its read
    run_burst(0, 16, 0, 1, 3, 5, 32'hDEAD_BEEF, 1'b0, 1'b0, fd, sp);
    check("wr_stall_span", 32'(sp), 32'd19);

    // Rejected requests
    invalid_start(0);
    invalid_start(17);
    run_burst(9, 5, 0, -1, 0, 0, 32'd0, 1'b0, 1'b1, fd, sp);

    // Reset mid-burst
    d0 = done_count;
    begin_burst(0, 16);
    tick();
    start = 1'b0;
    t = 0;
    while ((delivered < 3) && (t < 100)) begin
      tick();
      t++;
    end
    check("rst_reach3", 32'(delivered >= 3), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_active = 1'b0;
    check("abort_valid", 32'(out_if.out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (6) tick();
    check("abort_no_done", 32'(done_count - d0), 32'd0);
    run_burst(3, 7, 0, -1, 0, 0, 32'd0, 1'b0, 1'b0, fd, sp);
    check("post_rst_span", 32'(sp), 32'd7);

    // Randomized bursts
    for (int b = 0; b < 25; b++) begin
      if ($urandom_range(0, 3) == 0)
        invalid_start(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 31));
      run_burst($urandom_range(0, 15), $urandom_range(1, 16), 2, -1, 0, 0, 32'd0,
                1'b1, 1'($urandom_range(0, 1)), fd, sp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
